// File: rtl/matrix_scan_ctrl_pkg.sv
// Shared constants, swap FSM encoding and column decode for the LED matrix scanner.
package matrix_pkg;

   localparam int DEF_NUM_COLS     = 5;
   localparam int DEF_NUM_ROWS     = 7;
   localparam int DEF_SCAN_DIV     = 1000;
   localparam int DEF_BLANK_CYCLES = 1;

   // Widest column drive the decoder supports.
   localparam int MAX_COLS  = 32;
   localparam int COL_IDX_W = 5;

   typedef enum logic {
      SW_IDLE = 1'b0,
      SW_PEND = 1'b1
   } swap_state_e;

   function automatic logic [MAX_COLS-1:0] onehot(input logic [COL_IDX_W-1:0] idx);
      logic [MAX_COLS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/matrix_scan_ctrl_if.sv
// Frame-buffer write / swap handshake and matrix drive signals.
interface matrix_scan_if
   import matrix_pkg::*;
#(
   parameter int NUM_COLS = DEF_NUM_COLS,
   parameter int NUM_ROWS = DEF_NUM_ROWS
);
   localparam int COL_W = $clog2(NUM_COLS);

   logic                WR_EN;
   logic [COL_W-1:0]    WR_COL;
   logic [NUM_ROWS-1:0] WR_DATA;
   logic                SWAP_REQ;
   logic                SWAP_BUSY;
   logic                SWAP_DONE;
   logic [NUM_COLS-1:0] COL;
   logic [NUM_ROWS-1:0] ROW;
   logic                FRAME_START;

   modport master (
      output WR_EN, WR_COL, WR_DATA, SWAP_REQ,
      input  SWAP_BUSY, SWAP_DONE, COL, ROW, FRAME_START
   );

   modport slave (
      input  WR_EN, WR_COL, WR_DATA, SWAP_REQ,
      output SWAP_BUSY, SWAP_DONE, COL, ROW, FRAME_START
   );

endinterface

// File: rtl/matrix_scan_ctrl_scan_prescaler.sv
// Column dwell divider: counts 0..DIV-1 while enabled, ticks on the last count.
module scan_prescaler #(
   parameter  int DIV = 4,
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          EN,
   output logic          TICK,
   output logic [CW-1:0] CNT
);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          at_end;

   assign at_end = (cnt_q == CW'(DIV - 1));

   // advance while enabled, wrap to zero after the terminal count
   always_comb begin
      cnt_d = cnt_q;
      if (EN) begin
         cnt_d = at_end ? '0 : cnt_q + 1'b1;
      end
   end

   // count register
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign TICK = EN & at_end;
   assign CNT  = cnt_q;

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Column-multiplexed LED matrix scanner with double-buffered frame memory.
//
// Swap FSM:
//   state   | meaning
//   SW_IDLE | no swap requested; back bank accepts writes
//   SW_PEND | swap requested; writes dropped until the banks exchange
//
// All outputs are registered from the look-ahead of the scan position, so the
// drive seen in a cycle belongs to the divider/column value of that cycle. The
// first enabled edge after reset holds the counters so that position 0 of
// column 0 is actually displayed (with FRAME_START) before the scan advances.
module matrix_scan_ctrl
   import matrix_pkg::*;
#(
   parameter int NUM_COLS     = DEF_NUM_COLS,
   parameter int NUM_ROWS     = DEF_NUM_ROWS,
   parameter int SCAN_DIV     = DEF_SCAN_DIV,
   parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         EN,
   matrix_scan_if.slave bus
);
   localparam int               COL_W    = $clog2(NUM_COLS);
   localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

   logic                adv_en, tick, wrap_tick, blank, swap_go, wr_ok;
   logic [DIV_W-1:0]    div_cnt, div_nxt;
   logic [COL_W-1:0]    col_idx_q, col_idx_d;
   logic                first_q, first_d;
   logic                bank_sel_q, bank_sel_d;
   logic [NUM_ROWS-1:0] bank_q [2][NUM_COLS];
   logic [NUM_ROWS-1:0] bank_d [2][NUM_COLS];
   swap_state_e         swap_q, swap_d;
   logic                swap_done_q, swap_done_d;
   logic [NUM_COLS-1:0] col_q, col_d;
   logic [NUM_ROWS-1:0] row_q, row_d;
   logic                frame_start_q, frame_start_d;

   assign adv_en    = EN & ~first_q;
   assign wrap_tick = tick & (col_idx_q == LAST_COL);
   assign wr_ok     = bus.WR_EN && (32'(bus.WR_COL) < 32'(NUM_COLS)) && (swap_q == SW_IDLE);

   scan_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
      .CLK  (CLK),
      .RST  (RST),
      .EN   (adv_en),
      .TICK (tick),
      .CNT  (div_cnt)
   );

   // look-ahead of divider and column index for the registered drive
   always_comb begin
      col_idx_d = col_idx_q;
      div_nxt   = div_cnt;
      first_d   = first_q;
      if (EN) begin
         first_d = 1'b0;
      end
      if (adv_en) begin
         div_nxt = tick ? '0 : div_cnt + 1'b1;
      end
      if (tick) begin
         col_idx_d = (col_idx_q == LAST_COL) ? '0 : col_idx_q + 1'b1;
      end
   end

   if (BLANK_CYCLES > 0) begin : g_blank
      assign blank = (32'(div_nxt) < 32'(BLANK_CYCLES));
   end else begin : g_no_blank
      assign blank = 1'b0;
   end

   // swap FSM: latch a request, then exchange at frame wrap (or at once when idle)
   always_comb begin
      swap_d  = swap_q;
      swap_go = 1'b0;
      case (swap_q)
         SW_IDLE: begin
            if (bus.SWAP_REQ) begin
               swap_d = SW_PEND;
            end
         end
         SW_PEND: begin
            if (EN ? wrap_tick : 1'b1) begin
               swap_go = 1'b1;
               swap_d  = SW_IDLE;
            end
         end
         default: swap_d = SW_IDLE;
      endcase
   end

   // back-bank write port and bank select flip
   always_comb begin
      bank_d     = bank_q;
      bank_sel_d = bank_sel_q ^ swap_go;
      if (wr_ok) begin
         bank_d[~bank_sel_q][bus.WR_COL] = bus.WR_DATA;
      end
   end

   // drive for the upcoming cycle; front bank content never changes on a swap edge
   always_comb begin
      col_d         = '0;
      row_d         = '0;
      swap_done_d   = swap_go;
      frame_start_d = EN & (first_q | wrap_tick);
      if (EN && !blank) begin
         col_d = NUM_COLS'(onehot(COL_IDX_W'(col_idx_d)));
         row_d = bank_q[bank_sel_d][col_idx_d];
      end
   end

   // state and output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         col_idx_q     <= '0;
         first_q       <= 1'b1;
         bank_sel_q    <= 1'b0;
         bank_q        <= '{default: '0};
         swap_q        <= SW_IDLE;
         swap_done_q   <= 1'b0;
         col_q         <= '0;
         row_q         <= '0;
         frame_start_q <= 1'b0;
      end else begin
         col_idx_q     <= col_idx_d;
         first_q       <= first_d;
         bank_sel_q    <= bank_sel_d;
         bank_q        <= bank_d;
         swap_q        <= swap_d;
         swap_done_q   <= swap_done_d;
         col_q         <= col_d;
         row_q         <= row_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bus.SWAP_BUSY   = (swap_q == SW_PEND);
   assign bus.SWAP_DONE   = swap_done_q;
   assign bus.COL         = col_q;
   assign bus.ROW         = row_q;
   assign bus.FRAME_START = frame_start_q;

endmodule

// File: doc/matrix_scan_ctrl.md
MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 Parameter NUM_COLS, default 5, column count of the LED matrix (>=2).
REQ-002 Parameter NUM_ROWS, default 7, row count of the LED matrix (>=1).
REQ-003 Parameter SCAN_DIV, default 1000, CLK cycles per column dwell (>BLANK_CYCLES).
REQ-004 Parameter BLANK_CYCLES, default 1, all-off cycles at the start of each dwell (>=0).
REQ-005 Port CLK  input  1  single clock; all logic SHALL run on the rising edge; one clock; reset is synchronous and active-high.
REQ-006 Port RST  input  1  synchronous, active-high reset.
REQ-007 Port EN  input  1  scan enable.
REQ-008 Port WR_EN  input  1  write strobe to the back frame bank.
REQ-009 Port WR_COL  input  clog2(NUM_COLS)  column index to write.
REQ-010 Port WR_DATA  input  NUM_ROWS  row word for WR_COL; bit 0 = top row.
REQ-011 Port SWAP_REQ  input  1  request to exchange front and back banks.
REQ-012 Port SWAP_BUSY  output  1  swap pending.
REQ-013 Port SWAP_DONE  output  1  one-cycle pulse when the swap takes effect.
REQ-014 Port COL  output  NUM_COLS  one-hot column drive, active-high.
REQ-015 Port ROW  output  NUM_ROWS  row drive for the active column, active-high.
REQ-016 Port FRAME_START  output  1  one-cycle pulse when column 0 begins a new dwell.

Function
REQ-017 The divider SHALL count 0..SCAN_DIV-1 while EN=1 and emit a tick on SCAN_DIV-1, then wrap to 0.
REQ-018 Each tick SHALL advance col_idx by 1, wrapping NUM_COLS-1 -> 0.
REQ-019 While div_cnt < BLANK_CYCLES, COL and ROW SHALL be 0; otherwise COL = one-hot(col_idx) and ROW = front_bank[col_idx].
REQ-020 COL, ROW, FRAME_START, SWAP_BUSY and SWAP_DONE SHALL be registered, with no combinational path from any input.
REQ-021 FRAME_START SHALL pulse for the first cycle of each column-0 dwell, i.e. once per NUM_COLS*SCAN_DIV cycles.
REQ-022 With EN=0, div_cnt and col_idx SHALL hold, and COL=0 and ROW=0.
REQ-023 WR_EN=1 with WR_COL<NUM_COLS and SWAP_BUSY=0 SHALL write WR_DATA into back_bank[WR_COL] on that edge.
REQ-024 Writes with WR_COL>=NUM_COLS, or while SWAP_BUSY=1, SHALL be dropped.
REQ-025 SWAP_REQ=1 while SWAP_BUSY=0 SHALL set SWAP_BUSY on the next edge; SWAP_REQ while busy SHALL be ignored.
REQ-026 With EN=1, a pending swap SHALL execute on the tick where col_idx wraps to 0, so front and back banks are never swapped mid-frame.
REQ-027 If SWAP_REQ arrives in the same cycle as the wrap tick, the swap SHALL wait for the following wrap.
REQ-028 With EN=0, a pending swap SHALL execute on the edge after SWAP_BUSY rises.
REQ-029 On the swap edge, the bank select SHALL toggle, SWAP_BUSY SHALL clear, and SWAP_DONE SHALL pulse one cycle; the old front bank becomes the back bank unchanged.

Reset
REQ-030 RST=1 SHALL clear div_cnt, col_idx, bank select, both banks, SWAP_BUSY, SWAP_DONE, COL, ROW and FRAME_START to 0; this holds mid-frame and with a swap pending.
REQ-031 The first cycle after RST deasserts with EN=1 SHALL be div_cnt=0, col_idx=0, and SHALL carry a FRAME_START pulse.

Structure
REQ-032 Shared package matrix_pkg SHALL hold the default geometry constants (5, 7), the default SCAN_DIV, and the one-hot decode function.
REQ-033 The divider SHALL be a sub-module scan_prescaler (parameter DIV; ports CLK, RST, EN, TICK, CNT).

Verification (NUM_COLS=5, NUM_ROWS=7, SCAN_DIV=4, BLANK_CYCLES=1)
REQ-034 Reset, EN=1, no writes -> COL sequence 00000,00001x3,00000,00010x3,... ; ROW=0 throughout; FRAME_START every 20 cycles.
REQ-035 Write columns 0..4 = 0x3E,0x51,0x49,0x45,0x3E, then SWAP_REQ mid-frame -> SWAP_BUSY until the next wrap, SWAP_DONE coincident with FRAME_START, then ROW=0x3E when COL=00001 and ROW=0x51 when COL=00010.
REQ-036 Write col2=0x7F while SWAP_BUSY, plus a second SWAP_REQ -> exactly one SWAP_DONE; after the next swap back to that bank, col2 still holds its prior value.
REQ-037 EN=0 with SWAP_REQ -> COL=ROW=0; SWAP_DONE exactly 2 cycles after SWAP_REQ; col_idx unchanged when EN returns to 1.
REQ-038 WR_COL=5 with WR_DATA=0x7F -> no bank change.
REQ-039 RST mid-frame with a swap pending -> next cycle all outputs 0, SWAP_BUSY=0, and both banks read 0 after rescan.
